// File: rtl/nts_api_pkg.sv
// Shared constants and state encoding for the API bus arbiter.
package nts_api_pkg;

  localparam int unsigned API_ADDR_BITS = 8;
  localparam int unsigned API_DATA_BITS = 32;

  // Wide enough for the largest supported read latency (7).
  localparam int unsigned LAT_BITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage : nts_api_pkg

// File: rtl/nts_api_arbiter_if.sv
// Master-side request/ack signals and the API slave fabric signals of the
// arbiter, bundled so the arbiter and its neighbours share one port list.
interface nts_api_arbiter_if
  import nts_api_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned API_SLAVE_BITS = 1
);

  localparam int unsigned NUM_SLAVES = 2**API_SLAVE_BITS;

  // Master side
  logic [NUM_MASTERS-1:0]                i_req;
  logic [NUM_MASTERS-1:0]                i_we;
  logic [API_SLAVE_BITS*NUM_MASTERS-1:0] i_slave;
  logic [API_ADDR_BITS*NUM_MASTERS-1:0]  i_address;
  logic [API_DATA_BITS*NUM_MASTERS-1:0]  i_write_data;
  logic [NUM_MASTERS-1:0]                o_ack;
  logic [API_DATA_BITS-1:0]              o_read_data;
  logic                                  o_busy;

  // API slave fabric side
  logic [NUM_SLAVES-1:0]                 o_api_cs;
  logic                                  o_api_we;
  logic [API_ADDR_BITS-1:0]              o_api_address;
  logic [API_DATA_BITS-1:0]              o_api_write_data;
  logic [API_DATA_BITS*NUM_SLAVES-1:0]   i_api_read_data;

  // Arbiter view
  modport slave (
    input  i_req, i_we, i_slave, i_address, i_write_data, i_api_read_data,
    output o_ack, o_read_data, o_busy,
    output o_api_cs, o_api_we, o_api_address, o_api_write_data
  );

  // Environment view: the requesting masters plus the slave fabric
  modport master (
    output i_req, i_we, i_slave, i_address, i_write_data, i_api_read_data,
    input  o_ack, o_read_data, o_busy,
    input  o_api_cs, o_api_we, o_api_address, o_api_write_data
  );

endinterface : nts_api_arbiter_if

// File: rtl/nts_api_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant,
// wrapping explicitly at NUM_MASTERS-1 so non-power-of-two counts work.
module nts_api_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned MASTER_BITS = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MASTER_BITS-1:0] last_grant,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [MASTER_BITS-1:0] grant_index,
  output logic                   grant_valid
);

  localparam logic [MASTER_BITS-1:0] LAST_INDEX = MASTER_BITS'(NUM_MASTERS - 1);

  logic [MASTER_BITS-1:0] cand;

  // Walk the candidates starting after last_grant; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    cand        = last_grant;
    for (int unsigned step = 0; step < NUM_MASTERS; step++) begin
      cand = (cand == LAST_INDEX) ? '0 : cand + MASTER_BITS'(1);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_index = cand;
      end
    end
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      grant[m] = grant_valid && (grant_index == MASTER_BITS'(m));
    end
  end

endmodule : nts_api_rr_arbiter

// File: rtl/nts_api_arbiter.sv
// Shares the internal API bus between several masters. One transaction at a
// time: round-robin grant, single-cycle chip-select strobe, optional fixed
// read latency, then a one-cycle ack to the granted master.
module nts_api_arbiter
  import nts_api_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned MASTER_BITS    = 1,
  parameter int unsigned API_SLAVE_BITS = 1,
  parameter int unsigned READ_LATENCY   = 0
) (
  input logic              i_clk,
  input logic              i_areset_n,
  nts_api_arbiter_if.slave bus
);

  localparam int unsigned NUM_SLAVES = 2**API_SLAVE_BITS;

  arb_state_t state;
  arb_state_t state_nxt;

  logic [NUM_MASTERS-1:0]    rr_grant;
  logic [MASTER_BITS-1:0]    rr_index;
  logic                      rr_valid;

  logic [MASTER_BITS-1:0]    last_grant;
  logic [NUM_MASTERS-1:0]    grant_q;
  logic                      we_q;
  logic [API_SLAVE_BITS-1:0] slave_q;
  logic [API_ADDR_BITS-1:0]  address_q;
  logic [API_DATA_BITS-1:0]  write_data_q;
  logic [API_DATA_BITS-1:0]  read_data_q;
  logic [LAT_BITS-1:0]       lat_cnt;

  logic                      sel_we;
  logic [API_SLAVE_BITS-1:0] sel_slave;
  logic [API_ADDR_BITS-1:0]  sel_address;
  logic [API_DATA_BITS-1:0]  sel_write_data;
  logic [API_DATA_BITS-1:0]  slave_read_data;
  logic [NUM_SLAVES-1:0]     api_cs;
  logic                      sample_read;
  logic                      accept;

  nts_api_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .MASTER_BITS (MASTER_BITS)
  ) u_rr (
    .req         (bus.i_req),
    .last_grant  (last_grant),
    .grant       (rr_grant),
    .grant_index (rr_index),
    .grant_valid (rr_valid)
  );

  assign accept = (state == IDLE) && rr_valid;

  // Select the request fields of the master picked this cycle.
  always_comb begin
    sel_we         = 1'b0;
    sel_slave      = '0;
    sel_address    = '0;
    sel_write_data = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (rr_grant[m]) begin
        sel_we         = bus.i_we[m];
        sel_slave      = bus.i_slave[m*API_SLAVE_BITS +: API_SLAVE_BITS];
        sel_address    = bus.i_address[m*API_ADDR_BITS +: API_ADDR_BITS];
        sel_write_data = bus.i_write_data[m*API_DATA_BITS +: API_DATA_BITS];
      end
    end
  end

  // Read-data slice of the captured slave.
  always_comb begin
    slave_read_data = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (slave_q == API_SLAVE_BITS'(s)) begin
        slave_read_data = bus.i_api_read_data[s*API_DATA_BITS +: API_DATA_BITS];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and read-sample strobe.
  always_comb begin
    state_nxt   = state;
    sample_read = 1'b0;
    unique case (state)
      IDLE: begin
        if (rr_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_nxt = DONE;
        end else if (READ_LATENCY == 0) begin
          sample_read = 1'b1;
          state_nxt   = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Counter hits zero on this edge: sample READ_LATENCY cycles after ISSUE.
        if (lat_cnt == LAT_BITS'(1)) begin
          sample_read = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant capture, round-robin pointer, latency counter and read register.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      last_grant   <= MASTER_BITS'(NUM_MASTERS - 1);
      grant_q      <= '0;
      we_q         <= 1'b0;
      slave_q      <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      read_data_q  <= '0;
      lat_cnt      <= '0;
    end else begin
      if (accept) begin
        last_grant   <= rr_index;
        grant_q      <= rr_grant;
        we_q         <= sel_we;
        slave_q      <= sel_slave;
        address_q    <= sel_address;
        write_data_q <= sel_write_data;
      end
      if (state == ISSUE) begin
        lat_cnt <= LAT_BITS'(READ_LATENCY);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - LAT_BITS'(1);
      end
      if (sample_read) begin
        read_data_q <= slave_read_data;
      end
    end
  end

  // One-hot chip-select, live only during ISSUE.
  always_comb begin
    api_cs = '0;
    if (state == ISSUE) begin
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
        api_cs[s] = (slave_q == API_SLAVE_BITS'(s));
      end
    end
  end

  assign bus.o_api_cs         = api_cs;
  assign bus.o_api_we         = (state == ISSUE) && we_q;
  assign bus.o_api_address    = address_q;
  assign bus.o_api_write_data = write_data_q;
  assign bus.o_ack            = (state == DONE) ? grant_q : '0;
  assign bus.o_read_data      = read_data_q;
  assign bus.o_busy           = (state != IDLE);

endmodule : nts_api_arbiter

// File: tb/tb_nts_api_arbiter.sv
// Directed bench for nts_api_arbiter: one instance with zero read latency,
// one with a read latency of 3; expected acks/read data go through a queue.
module tb_nts_api_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  nts_api_arbiter_if #(.NUM_MASTERS(2), .API_SLAVE_BITS(1)) bus0 ();
  nts_api_arbiter_if #(.NUM_MASTERS(2), .API_SLAVE_BITS(1)) bus3 ();

  nts_api_arbiter #(
    .NUM_MASTERS(2), .MASTER_BITS(1), .API_SLAVE_BITS(1), .READ_LATENCY(0)
  ) u_dut0 (
    .i_clk(clk), .i_areset_n(rst_n), .bus(bus0)
  );

  nts_api_arbiter #(
    .NUM_MASTERS(2), .MASTER_BITS(1), .API_SLAVE_BITS(1), .READ_LATENCY(3)
  ) u_dut3 (
    .i_clk(clk), .i_areset_n(rst_n), .bus(bus3)
  );

  logic [31:0] sd0 [2];
  logic [31:0] sd3 [2];
  assign bus0.i_api_read_data = {sd0[1], sd0[0]};
  assign bus3.i_api_read_data = {sd3[1], sd3[0]};

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rd0 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] ack, input logic [31:0] rd, input int lat);
    exp_t e;
    e.ack = ack;
    e.rd  = rd;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int k, input logic [1:0] ack, input logic [31:0] rd);
    exp_t e;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("ack_vec", 32'(ack), 32'(e.ack));
      check("read_data", rd, e.rd);
      check("ack_cycle", 32'(k), 32'(e.lat));
    end
  endtask

  task automatic drive(input bit on3, input int m, input logic we, input logic sl,
                       input logic [7:0] addr, input logic [31:0] wd);
    if (on3) begin
      bus3.i_we[m] = we;
      bus3.i_slave[m] = sl;
      bus3.i_address[m*8 +: 8] = addr;
      bus3.i_write_data[m*32 +: 32] = wd;
      bus3.i_req[m] = 1'b1;
    end else begin
      bus0.i_we[m] = we;
      bus0.i_slave[m] = sl;
      bus0.i_address[m*8 +: 8] = addr;
      bus0.i_write_data[m*32 +: 32] = wd;
      bus0.i_req[m] = 1'b1;
    end
  endtask

  // Follows one transaction from its IDLE cycle (k=0) to the ack.
  task automatic observe(input bit on3, input logic [1:0] exp_cs, input logic exp_we,
                         input logic [7:0] exp_addr, input logic [31:0] exp_wd, input int budget);
    bit got = 1'b0;
    logic [1:0] ack, cs;
    logic we;
    logic [7:0] addr;
    logic [31:0] wd, rd;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      ack  = on3 ? bus3.o_ack : bus0.o_ack;
      cs   = on3 ? bus3.o_api_cs : bus0.o_api_cs;
      we   = on3 ? bus3.o_api_we : bus0.o_api_we;
      addr = on3 ? bus3.o_api_address : bus0.o_api_address;
      wd   = on3 ? bus3.o_api_write_data : bus0.o_api_write_data;
      rd   = on3 ? bus3.o_read_data : bus0.o_read_data;
      if (k == 0) check("cs_idle", 32'(cs), 32'd0);
      if (k == 1) begin
        check("api_cs", 32'(cs), 32'(exp_cs));
        check("api_we", 32'(we), 32'(exp_we));
        check("api_addr", 32'(addr), 32'(exp_addr));
        check("api_wdata", wd, exp_wd);
      end
      if (ack != 2'b00) begin
        got = 1'b1;
        sb_check(k, ack, rd);
      end
    end
    check("ack_seen", 32'(got), 32'd1);
  endtask

  // Zero-latency transaction on bus0; leaves req high, returns at the ack.
  task automatic txn0(input int m, input logic we, input logic sl,
                      input logic [7:0] addr, input logic [31:0] wd);
    if (!we) last_rd0 = sd0[sl];
    push(2'b01 << m, last_rd0, 2);
    drive(1'b0, m, we, sl, addr, wd);
    observe(1'b0, 2'b01 << sl, we, addr, wd, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit prev;
    int nacks;
    int kk;
    logic seen;

    bus0.i_req = '0; bus0.i_we = '0; bus0.i_slave = '0; bus0.i_address = '0; bus0.i_write_data = '0;
    bus3.i_req = '0; bus3.i_we = '0; bus3.i_slave = '0; bus3.i_address = '0; bus3.i_write_data = '0;
    sd0[0] = 32'h0BADF00D; sd0[1] = 32'hDEADBEEF;
    sd3[0] = 32'h0;        sd3[1] = 32'hAAAA0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(bus0.o_ack), 32'd0);
    check("rst_busy", 32'(bus0.o_busy), 32'd0);
    check("rst_cs", 32'(bus0.o_api_cs), 32'd0);
    check("rst_rdata", bus0.o_read_data, 32'd0);
    check("rst_addr", 32'(bus0.o_api_address), 32'd0);
    check("rst_busy3", 32'(bus3.o_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Master 0 read from slave 1
    txn0(0, 1'b0, 1'b1, 8'h10, 32'h0);
    @(posedge clk); #1;
    bus0.i_req[0] = 1'b0;

    // Master 1 write to slave 0; read register must not change
    txn0(1, 1'b1, 1'b0, 8'h22, 32'h12345678);
    @(posedge clk); #1;
    bus0.i_req[1] = 1'b0;

    // Both masters requesting continuously: grants alternate starting at 0
    sd0[0] = 32'hA0A0A0A0; sd0[1] = 32'hB1B1B1B1;
    for (int i = 0; i < 6; i++) push((i % 2 == 0) ? 2'b01 : 2'b10, sd0[i % 2], 2);
    last_rd0 = sd0[1];
    drive(1'b0, 0, 1'b0, 1'b0, 8'h40, 32'h0);
    drive(1'b0, 1, 1'b0, 1'b1, 8'h41, 32'h0);
    nacks = 0; kk = 0; prev = 1'b0;
    for (int c = 0; c < 40 && nacks < 6; c++) begin
      @(negedge clk);
      if (prev) check("ack_one_cycle", 32'(bus0.o_ack), 32'd0);
      prev = 1'b0;
      if (bus0.o_ack != 2'b00) begin
        sb_check(kk, bus0.o_ack, bus0.o_read_data);
        nacks++;
        kk = 0;
        prev = 1'b1;
      end else begin
        kk++;
      end
    end
    check("fair_acks", 32'(nacks), 32'd6);
    @(posedge clk); #1;
    bus0.i_req = '0;
    @(negedge clk);
    check("ack_one_cycle", 32'(bus0.o_ack), 32'd0);
    @(negedge clk);
    check("no_extra_grant", 32'(bus0.o_busy), 32'd0);

    // Read latency 3: slave data changes exactly 3 cycles after cs
    push(2'b01, 32'h5555FFFF, 5);
    @(posedge clk); #1;
    drive(1'b1, 0, 1'b0, 1'b1, 8'h44, 32'h0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == 4) sd3[1] = 32'h5555FFFF;
      end
      @(negedge clk);
      if (k == 1) check("lat3_cs", 32'(bus3.o_api_cs), 32'b10);
      if (k >= 1 && k <= 5) check("lat3_busy", 32'(bus3.o_busy), 32'd1);
      if (bus3.o_ack != 2'b00) begin
        got = 1'b1;
        sb_check(k, bus3.o_ack, bus3.o_read_data);
      end
    end
    check("lat3_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus3.i_req = '0;
    @(negedge clk);
    check("lat3_idle", 32'(bus3.o_busy), 32'd0);

    // Reset during WAIT aborts; master 0 then wins again
    @(posedge clk); #1;
    sd3[0] = 32'h0F0F0F0F; sd3[1] = 32'h13579BDF;
    drive(1'b1, 0, 1'b0, 1'b1, 8'h50, 32'h0);
    drive(1'b1, 1, 1'b0, 1'b0, 8'h60, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("rr_after_m0_cs", 32'(bus3.o_api_cs), 32'b01);
        check("rr_after_m0_addr", 32'(bus3.o_api_address), 32'h60);
      end
    end
    check("wait_no_ack", 32'(bus3.o_ack), 32'd0);
    check("wait_busy", 32'(bus3.o_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(bus3.o_api_cs), 32'd0);
    check("abort_ack", 32'(bus3.o_ack), 32'd0);
    check("abort_busy", 32'(bus3.o_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_rd0 = '0;
    push(2'b01, 32'h13579BDF, 5);
    observe(1'b1, 2'b10, 1'b0, 8'h50, 32'h0, 12);
    @(posedge clk); #1;
    bus3.i_req[0] = 1'b0;
    push(2'b10, 32'h0F0F0F0F, 5);
    observe(1'b1, 2'b01, 1'b0, 8'h60, 32'h0, 12);
    @(posedge clk); #1;
    bus3.i_req = '0;

    // Req held past ack with a new address: back-to-back, no lost/duplicate ack
    sd0[0] = 32'h11112222; sd0[1] = 32'hDEADBEEF;
    txn0(0, 1'b0, 1'b0, 8'h30, 32'hCAFE0001);
    @(posedge clk); #1;
    txn0(0, 1'b0, 1'b1, 8'h31, 32'hCAFE0002);
    @(posedge clk); #1;
    bus0.i_req = '0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus0.o_ack != 2'b00) seen = 1'b1;
    end
    check("no_dup_ack", 32'(seen), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_nts_api_arbiter
